// File: rtl/vec_math_pkg.sv
// Shared types and 24.8 fixed-point helpers for the vector-normalize controller.
package vec_math_pkg;

  typedef enum logic [3:0] {
    IDLE, CHECK, MAGCHK, SQRT_GO, SQRT_WAIT, DIV_CLR, DIV_GO, DIV_WAIT, DONE
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_RANGE    = 2'd1,
    ERR_ZERO     = 2'd2,
    ERR_DIVFAULT = 2'd3
  } err_t;

  localparam logic [31:0] COMP_LIMIT_DEF = 32'h0004_0000;

  function automatic logic signed [31:0] mult_24_8(input logic signed [31:0] a,
                                                   input logic signed [31:0] b);
    logic signed [63:0] p;
    p = 64'(a) * 64'(b);
    return 32'(p >>> 8);
  endfunction

  function automatic logic signed [31:0] square_mag(input logic signed [31:0] x,
                                                    input logic signed [31:0] y,
                                                    input logic signed [31:0] z);
    return mult_24_8(x, x) + mult_24_8(y, y) + mult_24_8(z, z);
  endfunction

  // Signed compare avoids taking |c| of the most negative value.
  function automatic logic out_of_range(input logic signed [31:0] c,
                                        input logic signed [31:0] lim);
    return (c >= lim) || (c <= -lim);
  endfunction

endpackage

// File: rtl/vec_normalize_ctrl_if.sv
// Upstream vector input and downstream normalized result, valid/ready on both sides.
interface vec_normalize_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic [31:0] in_y;
  logic [31:0] in_z;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_x;
  logic [31:0] out_y;
  logic [31:0] out_z;
  logic [1:0]  out_err;
  logic        busy;

  modport master (
    output in_valid, in_x, in_y, in_z, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_z, out_err, busy
  );

  modport slave (
    input  in_valid, in_x, in_y, in_z, out_ready,
    output in_ready, out_valid, out_x, out_y, out_z, out_err, busy
  );
endinterface

// File: rtl/div.sv
// Iterative signed fixed-point divide val = round_half_even((a << FBITS) / b), fixed WIDTH+FBITS cycles.
// val is only written for a nonzero in-range quotient, so callers clear it through rst.
module div #(
  parameter int WIDTH = 32,
  parameter int FBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic             dbz,
  output logic             ovf,
  output logic [WIDTH-1:0] val
);
  localparam int NW = WIDTH + FBITS;
  localparam int CW = $clog2(NW);
  localparam logic [NW:0] QMAX = {{(NW-WIDTH+1){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  logic [NW-1:0]    num, quo, quo_n;
  logic [WIDTH-1:0] den, rem, rem_n, a_mag, b_mag, sres;
  logic [WIDTH:0]   rem_sh, rem_x2;
  logic [NW:0]      qr;
  logic [CW-1:0]    cnt;
  logic             ge, up, neg, running, ovf_n;

  always_comb begin
    a_mag  = a[WIDTH-1] ? -a : a;
    b_mag  = b[WIDTH-1] ? -b : b;
    rem_sh = {rem, num[NW-1]};
    ge     = rem_sh >= {1'b0, den};
    rem_n  = ge ? WIDTH'(rem_sh - {1'b0, den}) : rem_sh[WIDTH-1:0];
    quo_n  = (quo << 1) | NW'(ge);
    // Ties go to the even quotient.
    rem_x2 = {rem_n, 1'b0};
    up     = (rem_x2 > {1'b0, den}) || ((rem_x2 == {1'b0, den}) && quo_n[0]);
    qr     = {1'b0, quo_n} + {{NW{1'b0}}, up};
    ovf_n  = neg ? (qr > QMAX) : (qr >= QMAX);
    sres   = neg ? -qr[WIDTH-1:0] : qr[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num <= '0; quo <= '0; den <= '0; rem <= '0; cnt <= '0;
      neg <= 1'b0; running <= 1'b0;
      done <= 1'b0; dbz <= 1'b0; ovf <= 1'b0; val <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        num     <= {a_mag, {FBITS{1'b0}}};
        den     <= b_mag;
        rem     <= '0;
        quo     <= '0;
        cnt     <= '0;
        neg     <= a[WIDTH-1] ^ b[WIDTH-1];
        running <= 1'b1;
        dbz     <= 1'b0;
        ovf     <= 1'b0;
      end else if (running) begin
        num <= num << 1;
        rem <= rem_n;
        quo <= quo_n;
        cnt <= cnt + 1'b1;
        if (cnt == CW'(NW-1)) begin
          running <= 1'b0;
          done    <= 1'b1;
          dbz     <= (den == '0);
          ovf     <= (den != '0) && ovf_n;
          if ((den != '0) && !ovf_n && (qr != '0))
            val <= sres;
        end
      end
    end
  end
endmodule

// File: rtl/sqrt.sv
// Iterative fixed-point square root, one result bit per cycle; root = floor(sqrt(rad << FBITS)).
// No reset: a new start always restarts the unit and clears valid.
module sqrt #(
  parameter int WIDTH = 32,
  parameter int FBITS = 8
) (
  input  logic             clk,
  input  logic             start,
  input  logic [WIDTH-1:0] rad,
  output logic             valid,
  output logic [WIDTH-1:0] root
);
  localparam int RW = WIDTH + FBITS;
  localparam logic [RW-1:0] BIT0 = {2'b01, {(RW-2){1'b0}}};

  logic [RW-1:0] x, q, b;
  logic          running;

  always_ff @(posedge clk) begin
    if (start) begin
      x       <= {rad, {FBITS{1'b0}}};
      q       <= '0;
      b       <= BIT0;
      running <= 1'b1;
      valid   <= 1'b0;
    end else if (running) begin
      if (x >= q + b) begin
        x <= x - (q + b);
        q <= (q >> 1) + b;
      end else begin
        q <= q >> 1;
      end
      b <= b >> 2;
      if (b == RW'(1)) begin
        running <= 1'b0;
        valid   <= 1'b1;
      end
    end
  end

  assign root = q[WIDTH-1:0];
endmodule

// File: rtl/vec_normalize_ctrl.sv
// Normalizes one signed 24.8 3-vector per transaction: range/zero checks, one sqrt, three
// time-multiplexed divides. Accepts only in IDLE; result is held in DONE until out_ready.
module vec_normalize_ctrl
  import vec_math_pkg::*;
#(
  parameter logic [31:0] COMP_LIMIT = COMP_LIMIT_DEF,
  parameter int          FBITS      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  vec_normalize_ctrl_if.slave  bus
);
  state_t      state, state_next;
  err_t        err;
  logic [31:0] vx, vy, vz, magsq, mag, res_x, res_y, res_z;
  logic [1:0]  k;
  logic        range_fail;
  logic        sqrt_start, sqrt_valid;
  logic [31:0] sqrt_root;
  logic        div_start, div_clr, div_rst, div_done, div_dbz, div_ovf;
  logic [31:0] div_a, div_val;

  assign range_fail = out_of_range(vx, COMP_LIMIT) | out_of_range(vy, COMP_LIMIT) |
                      out_of_range(vz, COMP_LIMIT);
  assign div_rst    = rst | div_clr;

  always_comb begin
    case (k)
      2'd0:    div_a = vx;
      2'd1:    div_a = vy;
      default: div_a = vz;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    sqrt_start = 1'b0;
    div_start  = 1'b0;
    div_clr    = 1'b0;
    case (state)
      IDLE:      if (bus.in_valid) state_next = CHECK;
      CHECK:     state_next = range_fail ? DONE : MAGCHK;
      MAGCHK:    state_next = (magsq == '0) ? DONE : SQRT_GO;
      SQRT_GO: begin
        sqrt_start = 1'b1;
        state_next = SQRT_WAIT;
      end
      SQRT_WAIT: if (sqrt_valid) state_next = DIV_CLR;
      // The divider keeps its old val on a zero quotient, so wipe it before every component.
      DIV_CLR: begin
        div_clr    = 1'b1;
        state_next = DIV_GO;
      end
      DIV_GO: begin
        div_start  = 1'b1;
        state_next = DIV_WAIT;
      end
      DIV_WAIT: begin
        if (div_done) begin
          if (div_dbz || div_ovf || (k == 2'd2)) state_next = DONE;
          else                                   state_next = DIV_CLR;
        end
      end
      DONE:      if (bus.out_ready) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vx <= '0; vy <= '0; vz <= '0; magsq <= '0; mag <= '0; k <= '0;
      res_x <= '0; res_y <= '0; res_z <= '0; err <= ERR_OK;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          vx <= bus.in_x; vy <= bus.in_y; vz <= bus.in_z;
        end
        CHECK: begin
          if (range_fail) begin
            err <= ERR_RANGE;
            res_x <= '0; res_y <= '0; res_z <= '0;
          end else begin
            magsq <= square_mag(vx, vy, vz);
          end
        end
        MAGCHK: if (magsq == '0) begin
          err <= ERR_ZERO;
          res_x <= '0; res_y <= '0; res_z <= '0;
        end
        SQRT_WAIT: if (sqrt_valid) begin
          mag <= sqrt_root;
          k   <= '0;
        end
        DIV_WAIT: if (div_done) begin
          if (div_dbz || div_ovf) begin
            err <= ERR_DIVFAULT;
            res_x <= '0; res_y <= '0; res_z <= '0;
          end else begin
            case (k)
              2'd0:    res_x <= div_val;
              2'd1:    res_y <= div_val;
              default: res_z <= div_val;
            endcase
            k <= k + 2'd1;
          end
        end
        DONE: if (bus.out_ready) err <= ERR_OK;
        default: ;
      endcase
    end
  end

  sqrt #(.WIDTH(32), .FBITS(FBITS)) u_sqrt (
    .clk   (clk),
    .start (sqrt_start),
    .rad   (magsq),
    .valid (sqrt_valid),
    .root  (sqrt_root)
  );

  div #(.WIDTH(32), .FBITS(FBITS)) u_div (
    .clk   (clk),
    .rst   (div_rst),
    .start (div_start),
    .a     (div_a),
    .b     (mag),
    .done  (div_done),
    .dbz   (div_dbz),
    .ovf   (div_ovf),
    .val   (div_val)
  );

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_x     = res_x;
  assign bus.out_y     = res_y;
  assign bus.out_z     = res_z;
  assign bus.out_err   = err;
endmodule

// File: tb/tb_vec_normalize_ctrl.sv
// Directed and randomized bench for vec_normalize_ctrl against a plain-arithmetic reference.
module tb_vec_normalize_ctrl;
  logic clk = 1'b0;
  logic rst;
  vec_normalize_ctrl_if bus();

  vec_normalize_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int failed = 0;
  int lat_ok = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic longint isqrt(input longint n);
    longint s;
    s = longint'($floor($sqrt(real'(n))));
    while (s * s > n) s--;
    while ((s + 1) * (s + 1) <= n) s++;
    return s;
  endfunction

  // Nearest quotient of c/m in 24.8, ties to even.
  function automatic logic [31:0] rdiv(input longint c, input longint m);
    longint n, an, q, r;
    n  = c * 256;
    an = (n < 0) ? -n : n;
    q  = an / m;
    r  = an % m;
    if ((2 * r > m) || ((2 * r == m) && (q % 2 == 1))) q = q + 1;
    if (n < 0) q = -q;
    return 32'(q);
  endfunction

  task automatic model(input logic [31:0] x, y, z,
                       output logic [31:0] ex, ey, ez, output logic [1:0] ee);
    longint c[3];
    longint msq, m;
    c[0] = longint'($signed(x));
    c[1] = longint'($signed(y));
    c[2] = longint'($signed(z));
    ee = 2'd0; ex = '0; ey = '0; ez = '0;
    msq = 0;
    for (int i = 0; i < 3; i++) begin
      if (((c[i] < 0) ? -c[i] : c[i]) >= 64'h40000) ee = 2'd1;
      msq += (c[i] * c[i]) / 256;
    end
    if (ee == 2'd0) begin
      if (msq == 0) ee = 2'd2;
      else begin
        m  = isqrt(msq * 256);
        ex = rdiv(c[0], m);
        ey = rdiv(c[1], m);
        ez = rdiv(c[2], m);
      end
    end
  endtask

  task automatic present(input logic [31:0] x, y, z);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!bus.in_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    bus.in_valid = 1'b1;
    bus.in_x = x; bus.in_y = y; bus.in_z = z;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_x = $urandom(); bus.in_y = $urandom(); bus.in_z = $urandom();
  endtask

  // Latency counts the accepting edge as 1.
  task automatic wait_result(output int lat, output logic [31:0] ox, oy, oz,
                             output logic [1:0] oe);
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < 2000) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("out_valid_seen", 32'(bus.out_valid), 32'd1);
    ox = bus.out_x; oy = bus.out_y; oz = bus.out_z; oe = bus.out_err;
  endtask

  task automatic run_vec(input logic [31:0] x, y, z, output int lat,
                         output logic [31:0] ox, oy, oz, output logic [1:0] oe);
    present(x, y, z);
    wait_result(lat, ox, oy, oz, oe);
  endtask

  task automatic retire(input int hold);
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("retire_out_valid", 32'(bus.out_valid), 32'd0);
    check("retire_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic check_model(input logic [31:0] x, y, z);
    logic [31:0] ex, ey, ez, ox, oy, oz;
    logic [1:0]  ee, oe;
    int          lat, elat;
    model(x, y, z, ex, ey, ez, ee);
    run_vec(x, y, z, lat, ox, oy, oz, oe);
    elat = (ee == 2'd1) ? 2 : (ee == 2'd2) ? 3 : lat_ok;
    check("model_x", ox, ex);
    check("model_y", oy, ey);
    check("model_z", oz, ez);
    check("model_err", 32'(oe), 32'(ee));
    check("model_lat", 32'(lat), 32'(elat));
    retire($urandom_range(3));
  endtask

  function automatic logic [31:0] rnd_comp();
    logic [31:0] m;
    case ($urandom_range(9))
      0, 1:    m = 32'd0;
      2, 3:    m = $urandom_range(32'h40);
      4, 5, 6: m = $urandom_range(32'h3FFFF);
      7, 8:    m = $urandom_range(32'h3FFFF, 32'h3FF00);
      default: m = $urandom_range(32'h50000, 32'h40000);
    endcase
    if ($urandom_range(1) == 1) m = -m;
    return m;
  endfunction

  initial begin
    int          lat, spur;
    logic [31:0] ox, oy, oz;
    logic [1:0]  oe;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_x = '0; bus.in_y = '0; bus.in_z = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_out_x", bus.out_x, 32'd0);
    check("rst_out_y", bus.out_y, 32'd0);
    check("rst_out_z", bus.out_z, 32'd0);
    check("rst_out_err", 32'(bus.out_err), 32'd0);
    rst = 1'b0;

    run_vec(32'h300, 32'h400, 32'h0, lat, ox, oy, oz, oe);
    lat_ok = lat;
    check("v345_x", ox, 32'h9A);
    check("v345_y", oy, 32'hCD);
    check("v345_z", oz, 32'h0);
    check("v345_err", 32'(oe), 32'd0);
    retire(0);

    run_vec(-32'sh300, 32'h0, 32'h400, lat, ox, oy, oz, oe);
    check("neg_x", ox, 32'hFFFF_FF66);
    check("neg_y", oy, 32'h0);
    check("neg_z", oz, 32'hCD);
    check("neg_err", 32'(oe), 32'd0);
    check("neg_lat", 32'(lat), 32'(lat_ok));
    retire(1);

    run_vec(32'h300, 32'h400, 32'h0, lat, ox, oy, oz, oe);
    retire(0);
    run_vec(32'h0, 32'h0, 32'h200, lat, ox, oy, oz, oe);
    check("stale_x", ox, 32'h0);
    check("stale_y", oy, 32'h0);
    check("stale_z", oz, 32'h100);
    check("stale_lat", 32'(lat), 32'(lat_ok));
    retire(0);

    run_vec(32'h0, 32'h0, 32'h0, lat, ox, oy, oz, oe);
    check("zero_err", 32'(oe), 32'd2);
    check("zero_out", ox | oy | oz, 32'd0);
    check("zero_lat", 32'(lat), 32'd3);
    retire(0);
    run_vec(32'h0004_0000, 32'h0, 32'h0, lat, ox, oy, oz, oe);
    check("range_err", 32'(oe), 32'd1);
    check("range_out", ox | oy | oz, 32'd0);
    check("range_lat", 32'(lat), 32'd2);
    retire(0);

    // Boundaries around the component limit and the magsq truncation to zero.
    check_model(32'h0003_FFFF, 32'h0, 32'h0);
    check_model(32'h0, -32'sh3FFFF, 32'h0);
    check_model(32'h0, 32'h0, -32'sh40000);
    check_model(32'hF, 32'h0, 32'h0);
    check_model(32'h10, 32'h0, 32'h0);
    check_model(32'h8000_0000, 32'h1, 32'h1);

    // Hold the result while a new vector waits upstream.
    run_vec(32'h300, 32'h400, 32'h0, lat, ox, oy, oz, oe);
    bus.in_valid = 1'b1;
    bus.in_x = 32'h0; bus.in_y = 32'h0; bus.in_z = 32'h0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_x", bus.out_x, 32'h9A);
      check("stall_y", bus.out_y, 32'hCD);
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("hs_out_valid", 32'(bus.out_valid), 32'd0);
    check("hs_in_ready", 32'(bus.in_ready), 32'd1);
    check("hs_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_result(lat, ox, oy, oz, oe);
    check("queued_err", 32'(oe), 32'd2);
    check("queued_lat", 32'(lat), 32'd3);
    retire(0);

    // Reset while the square root is in flight.
    present(32'h300, 32'h400, 32'h0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    spur = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) spur++;
    end
    check("no_spurious_valid", 32'(spur), 32'd0);
    run_vec(32'h300, 32'h400, 32'h0, lat, ox, oy, oz, oe);
    check("post_rst_x", ox, 32'h9A);
    check("post_rst_y", oy, 32'hCD);
    check("post_rst_z", oz, 32'h0);
    check("post_rst_err", 32'(oe), 32'd0);
    check("post_rst_lat", 32'(lat), 32'(lat_ok));
    retire(0);

    for (int i = 0; i < 24; i++) check_model(rnd_comp(), rnd_comp(), rnd_comp());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
